// File: rtl/an_code_pkg.sv
// Shared types and elaboration-time helpers for the AN-code decoder.
// pow2_mod/an_syndrome_lut are only ever evaluated with constant arguments.
package an_code_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} an_state_e;

    localparam int MAX_AN_W = 64;

    typedef struct packed {
        logic       hit;
        logic [7:0] pos;
    } syn_entry_t;

    function automatic int pow2_mod(input int i, input int a);
        int p;
        p = 1 % a;
        for (int k = 0; k < MAX_AN_W; k++) begin
            if (k < i) p = (2 * p) % a;
        end
        return p;
    endfunction

    // Table entry for residue r: the lowest bit whose +/- flip produces residue r.
    function automatic syn_entry_t an_syndrome_lut(input int r, input int a, input int an_w);
        syn_entry_t e;
        int         p;
        e = '0;
        if (r != 0) begin
            for (int i = 0; i < MAX_AN_W; i++) begin
                if (i < an_w && !e.hit) begin
                    p = pow2_mod(i, a);
                    if (p == r || (a - p) == r) begin
                        e.hit = 1'b1;
                        e.pos = 8'(i);
                    end
                end
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/an_const_div.sv
// Iterative restoring divider by the constant A: one quotient bit per cycle, MSB first.
// done pulses for one cycle once the last bit has been produced.
module an_const_div #(
    parameter int A    = 47,
    parameter int AN_W = 23,
    parameter int Q_W  = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AN_W-1:0] dividend,
    output logic            busy,
    output logic            done,
    output logic [Q_W-1:0]  quotient
);
    localparam int RES_W = $clog2(A);
    localparam int CNT_W = $clog2(AN_W);
    localparam logic [RES_W:0]   A_REM = (RES_W+1)'(A);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(AN_W - 1);

    logic [RES_W-1:0] rem_q, rem_d;
    logic [AN_W-1:0]  dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RES_W:0]   trial;

    // The dividend register shifts out its MSB and takes the quotient bit in at the LSB.
    always_comb begin
        trial  = {rem_q, dvd_q[AN_W-1]};
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            if (trial >= A_REM) begin
                rem_d = RES_W'(trial - A_REM);
                dvd_d = {dvd_q[AN_W-2:0], 1'b1};
            end else begin
                rem_d = trial[RES_W-1:0];
                dvd_d = {dvd_q[AN_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            rem_d  = '0;
            dvd_d  = dividend;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = dvd_q[Q_W-1:0];

endmodule

// File: rtl/an_decoder_seq.sv
// Handshaked AN-code decoder: residue check, single-bit correction, then divide by A.
// Optional feature macro AN_DEC_STATS_EN adds saturating correction/uncorrectable counters.
module an_decoder_seq #(
    parameter int A    = 47,
    parameter int N_W  = 17,
    parameter int AN_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AN_W-1:0]         in_an,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_W-1:0]          out_n,
    output logic                    out_corr,
    output logic                    out_uncorr,
    output logic [$clog2(AN_W)-1:0] out_pos
`ifdef AN_DEC_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [15:0]             stat_corr,
    output logic [15:0]             stat_uncorr
`endif
);
    import an_code_pkg::*;

    localparam int RES_W = $clog2(A);
    localparam int POS_W = $clog2(AN_W);
    localparam int LUT_N = 2 ** RES_W;
    localparam logic [AN_W-1:0] A_WORD = AN_W'(A);

    if (AN_W < N_W + $clog2(A)) begin : g_bad_width
        $error("an_decoder_seq: AN_W must be >= N_W + clog2(A)");
    end
    if (A < 3 || (A % 2) == 0) begin : g_bad_a
        $error("an_decoder_seq: A must be odd and >= 3");
    end
    if (AN_W > MAX_AN_W) begin : g_bad_an_w
        $error("an_decoder_seq: AN_W exceeds MAX_AN_W");
    end

    // Residues >= A cannot occur and never match, so those entries stay empty.
    logic [POS_W:0] lut [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam syn_entry_t ENTRY = an_syndrome_lut(g, A, AN_W);
        assign lut[g] = {ENTRY.hit, ENTRY.pos[POS_W-1:0]};
    end

    an_state_e        state_q, state_d;
    logic [AN_W-1:0]  an_q, an_d;
    logic [N_W-1:0]   out_n_q, out_n_d;
    logic             corr_q, corr_d;
    logic             uncorr_q, uncorr_d;
    logic [POS_W-1:0] pos_q, pos_d;

    logic [RES_W-1:0] residue;
    logic [POS_W:0]   syn;
    logic             syn_hit;
    logic [POS_W-1:0] syn_pos;
    logic [AN_W-1:0]  fixed_word;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [N_W-1:0]   div_quot;

    assign residue    = RES_W'(an_q % A_WORD);
    assign syn        = lut[residue];
    assign syn_hit    = syn[POS_W];
    assign syn_pos    = syn[POS_W-1:0];
    assign fixed_word = an_q ^ (syn_hit ? (AN_W'(1) << syn_pos) : '0);
    assign div_start  = (state_q == CHECK) && !div_busy;

    an_const_div #(
        .A    (A),
        .AN_W (AN_W),
        .Q_W  (N_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (fixed_word),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        state_d  = state_q;
        an_d     = an_q;
        out_n_d  = out_n_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        pos_d    = pos_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    an_d    = in_an;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                corr_d   = syn_hit;
                uncorr_d = (residue != '0) && !syn_hit;
                pos_d    = syn_hit ? syn_pos : '0;
                if (!div_busy) state_d = DIV;
            end
            DIV: begin
                if (div_done) begin
                    out_n_d = div_quot;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            an_q     <= '0;
            out_n_q  <= '0;
            corr_q   <= 1'b0;
            uncorr_q <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            an_q     <= an_d;
            out_n_q  <= out_n_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            pos_q    <= pos_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_n      = out_n_q;
    assign out_corr   = corr_q;
    assign out_uncorr = uncorr_q;
    assign out_pos    = pos_q;

`ifdef AN_DEC_STATS_EN
    logic [15:0] stat_corr_q, stat_corr_d;
    logic [15:0] stat_uncorr_q, stat_uncorr_d;
    logic        xfer;

    assign xfer = (state_q == DONE) && out_ready;

    // Clear takes priority over an increment landing in the same cycle.
    always_comb begin
        stat_corr_d   = stat_corr_q;
        stat_uncorr_d = stat_uncorr_q;
        if (stat_clr) begin
            stat_corr_d   = '0;
            stat_uncorr_d = '0;
        end else if (xfer) begin
            if (corr_q && stat_corr_q != 16'hFFFF)     stat_corr_d   = stat_corr_q + 16'd1;
            if (uncorr_q && stat_uncorr_q != 16'hFFFF) stat_uncorr_d = stat_uncorr_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_corr_q   <= '0;
            stat_uncorr_q <= '0;
        end else begin
            stat_corr_q   <= stat_corr_d;
            stat_uncorr_q <= stat_uncorr_d;
        end
    end

    assign stat_corr   = stat_corr_q;
    assign stat_uncorr = stat_uncorr_q;
`endif

endmodule
